// File: rtl/issue_scoreboard_queue.sv
// issue_scoreboard_queue: in-order issue FIFO whose head is gated by a per-register
// pending-write scoreboard retired through NWB writeback ports.
module issue_scoreboard_queue #(
    parameter int DEPTH = 4,
    parameter int NWB   = 2,
    parameter int CNT_W = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_pc,
    input  logic [31:0]                    in_inst,
    input  logic [4:0]                     in_rs1,
    input  logic [4:0]                     in_rs2,
    input  logic [4:0]                     in_rd,
    input  logic                           in_need_rs1,
    input  logic                           in_need_rs2,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_pc,
    output logic [31:0]                    out_inst,
    output logic [4:0]                     out_rd,
    input  logic [NWB-1:0]                 wb_valid,
    input  logic [5*NWB-1:0]               wb_rd,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           stall_raw,
    output logic [31:0]                    busy_mask
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] MAXC = '1;

    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];
    logic [4:0]       r_rs1  [DEPTH];
    logic [4:0]       r_rs2  [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic             r_n1   [DEPTH];
    logic             r_n2   [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_up;
    logic [CNT_W-1:0] r_pend [32];
    logic [CNT_W-1:0] w_next [32];
    logic [31:0]      w_under;
    logic [4:0]       w_rs1;
    logic [4:0]       w_rs2;
    logic             w_has;
    logic             w_raw;
    logic             w_sat;
    logic             w_block;
    logic             w_enq;
    logic             w_deq;

    assign w_rs1     = r_rs1[r_head];
    assign w_rs2     = r_rs2[r_head];
    assign out_pc    = r_pc[r_head];
    assign out_inst  = r_inst[r_head];
    assign out_rd    = r_rd[r_head];
    assign count     = r_count;
    assign w_has     = r_count != '0;
    // hazards look only at registered counters, so a writeback wakes the head one cycle later
    assign w_raw     = (r_n1[r_head] && w_rs1 != 5'd0 && r_pend[w_rs1] != '0) ||
                       (r_n2[r_head] && w_rs2 != 5'd0 && r_pend[w_rs2] != '0);
    assign w_sat     = out_rd != 5'd0 && r_pend[out_rd] == MAXC;
    assign w_block   = w_raw || w_sat;
    assign in_ready  = r_up && !flush && (r_count < CW'(DEPTH));
    assign out_valid = w_has && !w_block && !flush;
    assign stall_raw = w_has && w_block && !flush;
    assign w_enq     = in_valid && in_ready;
    assign w_deq     = out_valid && out_ready;

    always_comb begin
        int t;
        t         = 0;
        w_under   = '0;
        busy_mask = '0;
        w_next    = '{default: '0};
        for (int r = 1; r < 32; r++) begin
            t = int'(r_pend[r]) + ((w_deq && out_rd == 5'(r)) ? 1 : 0);
            for (int k = 0; k < NWB; k++)
                t = t - ((wb_valid[k] && wb_rd[5*k +: 5] == 5'(r)) ? 1 : 0);
            w_under[r]   = t < 0;
            w_next[r]    = (t < 0) ? '0 : CNT_W'(t);
            busy_mask[r] = r_pend[r] != '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_up    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
                r_rs1[i]  <= '0;
                r_rs2[i]  <= '0;
                r_rd[i]   <= '0;
                r_n1[i]   <= 1'b0;
                r_n2[i]   <= 1'b0;
            end
            for (int r = 0; r < 32; r++)
                r_pend[r] <= '0;
        end else begin
            r_up <= 1'b1;
            // counters survive a flush: discarded entries never issued, issued ones still write back
            for (int r = 0; r < 32; r++)
                r_pend[r] <= w_next[r];
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) begin
                    r_pc[r_tail]   <= in_pc;
                    r_inst[r_tail] <= in_inst;
                    r_rs1[r_tail]  <= in_rs1;
                    r_rs2[r_tail]  <= in_rs2;
                    r_rd[r_tail]   <= in_rd;
                    r_n1[r_tail]   <= in_need_rs1;
                    r_n2[r_tail]   <= in_need_rs2;
                    r_tail         <= r_tail + 1'b1;
                end
                if (w_deq)
                    r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset)
            assert (w_under == '0);
    end
`endif
endmodule
